assoc_tag_ctrl: RTL and testbench

//  Fully-associative tag controller for the BIU line cache. Resolves core hit/miss
//  and selects a replacement victim (first invalid entry, else least-frequently-used

---
 rtl/assoc_tag_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_assoc_tag_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_tag_ctrl.sv
// assoc_tag_ctrl: fully-associative tag array for the BIU line cache.
// LFU replacement with aging, dirty write-back, refill, sync and flush.
module assoc_tag_ctrl #(
   parameter int ENTRY_NUM   = 8,
   parameter int ADDR_WIDTH  = 32,
   parameter int LINE_OFFSET = 10,
   parameter int CNT_WIDTH   = 8,
   parameter int SEL_WIDTH   = $clog2(ENTRY_NUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  acc_read,
   input  logic                  acc_write,
   input  logic [ADDR_WIDTH-1:0] acc_addr,
   output logic                  hit,
   output logic [SEL_WIDTH-1:0]  hit_sel,
   output logic                  busy,
   output logic                  wb_req,
   output logic [SEL_WIDTH-1:0]  wb_sel,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic                  wb_ack,
   output logic                  refill_req,
   output logic [SEL_WIDTH-1:0]  refill_sel,
   output logic [ADDR_WIDTH-1:0] refill_addr,
   input  logic                  refill_done,
   input  logic                  sync_req,
   input  logic                  flush_req,
   output logic                  op_done
);
   localparam int TAG_W = ADDR_WIDTH - LINE_OFFSET;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_AGED =
      (CNT_MAX >> 1) + 1'b1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE, WB_VICTIM, REFILL, SCAN, WB_SCAN, DONE
   } state_t;

   state_t state, state_nx;

   logic [ENTRY_NUM-1:0] valid;
   logic [ENTRY_NUM-1:0] dirty;
   logic [TAG_W-1:0]     tag_q [ENTRY_NUM];
   logic [CNT_WIDTH-1:0] cnt_q [ENTRY_NUM];
   logic [SEL_WIDTH-1:0] vict_q;
   logic [SEL_WIDTH-1:0] scan_q;
   logic [TAG_W-1:0]     miss_tag;

   logic                 access;
   logic [TAG_W-1:0]     acc_tag;
   logic                 hit_any;
   logic [SEL_WIDTH-1:0] hit_idx;
   logic                 inv_any;
   logic [SEL_WIDTH-1:0] inv_idx;
   logic                 dty_any;
   logic [SEL_WIDTH-1:0] dty_idx;
   logic [SEL_WIDTH-1:0] lfu_idx;
   logic [CNT_WIDTH-1:0] lfu_min;
   logic [SEL_WIDTH-1:0] vict_idx;
   logic                 unused_off;

   assign access     = acc_read | acc_write;
   assign acc_tag    = acc_addr[ADDR_WIDTH-1:LINE_OFFSET];
   assign unused_off = ^acc_addr[LINE_OFFSET-1:0];

   // descending scan so the lowest matching index wins
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      inv_any = 1'b0;
      inv_idx = '0;
      dty_any = 1'b0;
      dty_idx = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (valid[i] && tag_q[i] == acc_tag) begin
            hit_any = 1'b1;
            hit_idx = SEL_WIDTH'(i);
         end
         if (!valid[i]) begin
            inv_any = 1'b1;
            inv_idx = SEL_WIDTH'(i);
         end
         if (valid[i] && dirty[i]) begin
            dty_any = 1'b1;
            dty_idx = SEL_WIDTH'(i);
         end
      end
   end

   always_comb begin
      lfu_idx = '0;
      lfu_min = cnt_q[0];
      for (int i = 1; i < ENTRY_NUM; i++) begin
         if (cnt_q[i] < lfu_min) begin
            lfu_min = cnt_q[i];
            lfu_idx = SEL_WIDTH'(i);
         end
      end
   end

   assign vict_idx = inv_any ? inv_idx : lfu_idx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (access) begin
               if (!hit_any) begin
                  if (valid[vict_idx] && dirty[vict_idx])
                     state_nx = WB_VICTIM;
                  else
                     state_nx = REFILL;
               end
            end else if (sync_req || flush_req) begin
               state_nx = SCAN;
            end
         end
         WB_VICTIM: if (wb_ack) state_nx = REFILL;
         REFILL:    if (refill_done) state_nx = IDLE;
         SCAN:      state_nx = dty_any ? WB_SCAN : DONE;
         WB_SCAN:   if (wb_ack) state_nx = SCAN;
         DONE:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_comb begin
      hit         = (state == IDLE) && access && hit_any;
      hit_sel     = hit ? hit_idx : '0;
      busy        = (state != IDLE);
      wb_req      = (state == WB_VICTIM) || (state == WB_SCAN);
      wb_sel      = '0;
      if (state == WB_VICTIM) wb_sel = vict_q;
      if (state == WB_SCAN)   wb_sel = scan_q;
      wb_addr     = '0;
      if (wb_req)
         wb_addr = {tag_q[wb_sel], {LINE_OFFSET{1'b0}}};
      refill_req  = (state == REFILL);
      refill_sel  = refill_req ? vict_q : '0;
      refill_addr = '0;
      if (refill_req)
         refill_addr = {miss_tag, {LINE_OFFSET{1'b0}}};
      op_done     = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         valid    <= '0;
         dirty    <= '0;
         vict_q   <= '0;
         scan_q   <= '0;
         miss_tag <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            cnt_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         state <= state_nx;
         if (hit) begin
            // halve everyone first so relative order survives
            if (cnt_q[hit_idx] == CNT_MAX) begin
               for (int i = 0; i < ENTRY_NUM; i++)
                  cnt_q[i] <= cnt_q[i] >> 1;
               cnt_q[hit_idx] <= CNT_AGED;
            end else begin
               cnt_q[hit_idx] <= cnt_q[hit_idx] + 1'b1;
            end
            if (acc_write) dirty[hit_idx] <= 1'b1;
         end
         if (state == IDLE && access && !hit_any) begin
            vict_q   <= vict_idx;
            miss_tag <= acc_tag;
         end
         if (state == WB_VICTIM && wb_ack)
            dirty[vict_q] <= 1'b0;
         if (state == REFILL && refill_done) begin
            tag_q[vict_q] <= miss_tag;
            valid[vict_q] <= 1'b1;
            dirty[vict_q] <= 1'b0;
            cnt_q[vict_q] <= CNT_ONE;
         end
         if (state == SCAN && dty_any)
            scan_q <= dty_idx;
         if (state == WB_SCAN && wb_ack)
            dirty[scan_q] <= 1'b0;
         if (state == DONE && flush_req) begin
            valid <= '0;
            for (int i = 0; i < ENTRY_NUM; i++)
               cnt_q[i] <= '0;
         end
      end
   end
endmodule

// File: tb/tb_assoc_tag_ctrl.sv
// tb_assoc_tag_ctrl: directed stimulus with an event scoreboard.
// u_dut uses 8-bit counters, u_sat uses 2-bit counters for aging.
module tb_assoc_tag_ctrl;
   localparam int K_HIT  = 0;
   localparam int K_WB   = 1;
   localparam int K_RF   = 2;
   localparam int K_DONE = 3;
   localparam int K_RST  = 4;

   typedef struct {
      int          kind;
      int          sel;
      logic [31:0] addr;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        acc_read, acc_write;
   logic [31:0] acc_addr;
   logic        hit, busy, wb_req, refill_req, op_done;
   logic [1:0]  hit_sel, wb_sel, refill_sel;
   logic [31:0] wb_addr, refill_addr;
   logic        wb_ack, refill_done, sync_req, flush_req;

   logic        s_read, s_write;
   logic [31:0] s_addr;
   logic        s_hit, s_busy, s_wb_req, s_refill_req, s_op_done;
   logic [1:0]  s_hit_sel, s_wb_sel, s_refill_sel;
   logic [31:0] s_wb_addr, s_refill_addr;
   logic        s_wb_ack, s_refill_done, s_sync, s_flush;

   assoc_tag_ctrl #(
      .ENTRY_NUM(4), .ADDR_WIDTH(32),
      .LINE_OFFSET(10), .CNT_WIDTH(8)
   ) u_dut (
      .clk(clk), .rst(rst),
      .acc_read(acc_read), .acc_write(acc_write),
      .acc_addr(acc_addr),
      .hit(hit), .hit_sel(hit_sel), .busy(busy),
      .wb_req(wb_req), .wb_sel(wb_sel),
      .wb_addr(wb_addr), .wb_ack(wb_ack),
      .refill_req(refill_req), .refill_sel(refill_sel),
      .refill_addr(refill_addr), .refill_done(refill_done),
      .sync_req(sync_req), .flush_req(flush_req),
      .op_done(op_done)
   );

   assoc_tag_ctrl #(
      .ENTRY_NUM(4), .ADDR_WIDTH(32),
      .LINE_OFFSET(10), .CNT_WIDTH(2)
   ) u_sat (
      .clk(clk), .rst(rst),
      .acc_read(s_read), .acc_write(s_write),
      .acc_addr(s_addr),
      .hit(s_hit), .hit_sel(s_hit_sel), .busy(s_busy),
      .wb_req(s_wb_req), .wb_sel(s_wb_sel),
      .wb_addr(s_wb_addr), .wb_ack(s_wb_ack),
      .refill_req(s_refill_req), .refill_sel(s_refill_sel),
      .refill_addr(s_refill_addr), .refill_done(s_refill_done),
      .sync_req(s_sync), .flush_req(s_flush),
      .op_done(s_op_done)
   );

   ev_t q_m[$];
   ev_t q_s[$];
   int  total = 0;
   int  bad   = 0;
   int  tmo   = 0;
   bit  fin_req = 1'b0;
   bit  fin_ack = 1'b0;

   function automatic string kn(input int k);
      case (k)
         K_HIT:   return "hit";
         K_WB:    return "wb";
         K_RF:    return "refill";
         K_DONE:  return "done";
         default: return "reset";
      endcase
   endfunction

   task automatic exp_m(input int k, input int s, input logic [31:0] a);
      ev_t e;
      e.kind = k; e.sel = s; e.addr = a;
      q_m.push_back(e);
   endtask

   task automatic exp_s(input int k, input int s, input logic [31:0] a);
      ev_t e;
      e.kind = k; e.sel = s; e.addr = a;
      q_s.push_back(e);
   endtask

   task automatic chk(input bit s, input int k, input int sel,
                      input logic [31:0] a);
      ev_t   e;
      string who;
      who = s ? "sat" : "main";
      total++;
      if ((s && q_s.size() == 0) || (!s && q_m.size() == 0)) begin
         bad++;
         $display("FAIL %s unexpected: got %s sel=%0d addr=%h, want none",
                  who, kn(k), sel, a);
      end else begin
         if (s) e = q_s.pop_front();
         else   e = q_m.pop_front();
         if (e.kind != k || e.sel != sel || e.addr != a) begin
            bad++;
            $display("FAIL %s %s: got %s sel=%0d addr=%h, want %s sel=%0d addr=%h",
                     who, kn(e.kind), kn(k), sel, a, kn(e.kind), e.sel, e.addr);
         end
      end
   endtask

   // monitor: turns DUT outputs into events and checks them in order
   initial begin
      logic wb_d, rf_d, swb_d, srf_d, rst_d;
      wb_d = 0; rf_d = 0; swb_d = 0; srf_d = 0; rst_d = 0;
      forever begin
         @(negedge clk);
         if (rst && rst_d) begin
            if (q_m.size() > 0 && q_m[0].kind == K_RST)
               chk(0, K_RST,
                   int'({busy, wb_req, refill_req, op_done, hit,
                         hit_sel, wb_sel, refill_sel}),
                   wb_addr | refill_addr);
            if (q_s.size() > 0 && q_s[0].kind == K_RST)
               chk(1, K_RST,
                   int'({s_busy, s_wb_req, s_refill_req, s_op_done, s_hit,
                         s_hit_sel, s_wb_sel, s_refill_sel}),
                   s_wb_addr | s_refill_addr);
         end else if (!rst) begin
            if (hit) chk(0, K_HIT, int'(hit_sel), 32'h0);
            if (wb_req && !wb_d) chk(0, K_WB, int'(wb_sel), wb_addr);
            if (refill_req && !rf_d)
               chk(0, K_RF, int'(refill_sel), refill_addr);
            if (op_done) chk(0, K_DONE, 0, 32'h0);
            if (s_hit) chk(1, K_HIT, int'(s_hit_sel), 32'h0);
            if (s_wb_req && !swb_d)
               chk(1, K_WB, int'(s_wb_sel), s_wb_addr);
            if (s_refill_req && !srf_d)
               chk(1, K_RF, int'(s_refill_sel), s_refill_addr);
            if (s_op_done) chk(1, K_DONE, 0, 32'h0);
         end
         wb_d = wb_req; rf_d = refill_req;
         swb_d = s_wb_req; srf_d = s_refill_req;
         rst_d = rst;
         if (fin_req && !fin_ack) begin
            total++;
            if (q_m.size() != 0) begin
               bad++;
               $display("FAIL main pending: got %0d events left, want 0",
                        q_m.size());
            end
            total++;
            if (q_s.size() != 0) begin
               bad++;
               $display("FAIL sat pending: got %0d events left, want 0",
                        q_s.size());
            end
            total++;
            if (tmo != 0) begin
               bad++;
               $display("FAIL timeouts: got %0d, want 0", tmo);
            end
            fin_ack = 1'b1;
         end
      end
   end

   // BIU model: acknowledge each request on its third sampled cycle
   initial begin
      int wc, rc, swc, src;
      wc = 0; rc = 0; swc = 0; src = 0;
      wb_ack = 0; refill_done = 0; s_wb_ack = 0; s_refill_done = 0;
      forever begin
         @(posedge clk);
         #1;
         wb_ack = 0; refill_done = 0; s_wb_ack = 0; s_refill_done = 0;
         wc  = wb_req       ? wc + 1  : 0;
         rc  = refill_req   ? rc + 1  : 0;
         swc = s_wb_req     ? swc + 1 : 0;
         src = s_refill_req ? src + 1 : 0;
         if (wc  == 3) begin wb_ack = 1;        wc  = 0; end
         if (rc  == 3) begin refill_done = 1;   rc  = 0; end
         if (swc == 3) begin s_wb_ack = 1;      swc = 0; end
         if (src == 3) begin s_refill_done = 1; src = 0; end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1;
      acc_read = 0; acc_write = 0;
      s_read = 0; s_write = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic acc(input bit s, input bit wr, input logic [31:0] a);
      int n;
      if (s) begin
         s_read = !wr; s_write = wr; s_addr = a;
      end else begin
         acc_read = !wr; acc_write = wr; acc_addr = a;
      end
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (s ? s_hit : hit) break;
      end
      if (n == 100) tmo++;
      @(posedge clk);
      #1;
      acc_read = 0; acc_write = 0; s_read = 0; s_write = 0;
   endtask

   task automatic op(input bit fl);
      int n;
      if (fl) flush_req = 1;
      else    sync_req  = 1;
      for (n = 0; n < 200; n++) begin
         @(negedge clk);
         if (op_done) break;
      end
      if (n == 200) tmo++;
      @(posedge clk);
      #1;
      sync_req = 0; flush_req = 0;
   endtask

   // read miss that refills sel, then the held access hits
   task automatic fill(input bit s, input bit wr, input logic [31:0] a,
                       input int sel);
      logic [31:0] line;
      line = {a[31:10], 10'h0};
      if (s) begin
         exp_s(K_RF, sel, line); exp_s(K_HIT, sel, 32'h0);
      end else begin
         exp_m(K_RF, sel, line); exp_m(K_HIT, sel, 32'h0);
      end
      acc(s, wr, a);
   endtask

   task automatic hit_m(input bit wr, input logic [31:0] a, input int sel);
      exp_m(K_HIT, sel, 32'h0);
      acc(0, wr, a);
   endtask

   task automatic hit_s(input logic [31:0] a, input int sel);
      exp_s(K_HIT, sel, 32'h0);
      acc(1, 0, a);
   endtask

   initial begin
      int n;
      rst = 1;
      acc_read = 0; acc_write = 0; acc_addr = 0;
      sync_req = 0; flush_req = 0;
      s_read = 0; s_write = 0; s_addr = 0;
      s_sync = 0; s_flush = 0;

      exp_m(K_RST, 0, 32'h0);
      exp_s(K_RST, 0, 32'h0);
      do_reset();

      // cold miss
      fill(0, 0, 32'h0000_1400, 0);
      // fill the rest; cnt = [4,2,3,3] after extra hits
      fill(0, 0, 32'h0000_2000, 1);
      fill(0, 0, 32'h0000_3000, 2);
      fill(0, 0, 32'h0000_4000, 3);
      hit_m(0, 32'h0000_1400, 0);
      hit_m(0, 32'h0000_17fc, 0);
      hit_m(0, 32'h0000_3000, 2);
      hit_m(0, 32'h0000_4000, 3);
      fill(0, 0, 32'h0000_8000, 1);

      // dirty entry2 becomes the LFU victim: cnt = [6,5,4,5]
      hit_m(1, 32'h0000_3004, 2);
      repeat (3) hit_m(0, 32'h0000_8000, 1);
      repeat (2) hit_m(0, 32'h0000_4000, 3);
      repeat (2) hit_m(0, 32'h0000_1400, 0);
      exp_m(K_WB, 2, 32'h0000_3000);
      fill(0, 0, 32'h0000_9123, 2);

      // flush with entries 0 and 3 dirty
      hit_m(1, 32'h0000_1400, 0);
      hit_m(1, 32'h0000_4010, 3);
      exp_m(K_WB, 0, 32'h0000_1400);
      exp_m(K_WB, 3, 32'h0000_4000);
      exp_m(K_DONE, 0, 32'h0);
      op(1);
      fill(0, 0, 32'h0000_1400, 0);

      // sync with nothing dirty keeps lines valid
      exp_m(K_DONE, 0, 32'h0);
      op(0);
      hit_m(0, 32'h0000_1400, 0);

      // reset while writing back a dirty victim
      fill(0, 1, 32'h0000_a000, 1);
      fill(0, 1, 32'h0000_b000, 2);
      fill(0, 1, 32'h0000_c000, 3);
      exp_m(K_WB, 1, 32'h0000_a000);
      exp_m(K_RST, 0, 32'h0);
      acc_read = 1;
      acc_addr = 32'h0000_d000;
      for (n = 0; n < 50; n++) begin
         @(negedge clk);
         if (wb_req) break;
      end
      if (n == 50) tmo++;
      do_reset();
      fill(0, 0, 32'h0000_a000, 0);

      // 2-bit counters: cnt = [2,1,1,1] after aging
      fill(1, 0, 32'h0000_1000, 0);
      fill(1, 0, 32'h0000_2000, 1);
      fill(1, 0, 32'h0000_3000, 2);
      fill(1, 0, 32'h0000_4000, 3);
      hit_s(32'h0000_2000, 1);
      hit_s(32'h0000_1000, 0);
      hit_s(32'h0000_1000, 0);
      fill(1, 0, 32'h0000_5000, 1);
      fill(1, 0, 32'h0000_6000, 2);
      fill(1, 0, 32'h0000_7000, 3);

      repeat (5) @(posedge clk);
      #1;
      fin_req = 1;
      for (n = 0; n < 20 && !fin_ack; n++) @(posedge clk);
      if (!fin_ack) begin
         bad++;
         total++;
         $display("FAIL finish: got no final check, want one");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
